// File: rtl/encoder_menu_ctrl_pkg.sv
// Shared types for the encoder menu controller.
// State encoding, BCD byte type and BCD limit.
package encoder_menu_ctrl_pkg;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [7:0] bcd_t;

  localparam bcd_t BCD_MAX = 8'h99;

endpackage

// File: rtl/encoder_menu_ctrl_bcd_step.sv
// Combinational two-digit BCD +1/-1 with wrap.
// din: BCD in; up/down: step request; dout: result.
module bcd_step
  import encoder_menu_ctrl_pkg::*;
(
  input  bcd_t din,
  input  logic up,
  input  logic down,
  output bcd_t dout
);

  // Both or neither request: pass through.
  always_comb begin
    dout = din;
    if (up && !down) begin
      if (din == BCD_MAX)
        dout = '0;
      else if (din[3:0] == 4'd9)
        dout = {din[7:4] + 4'd1, 4'd0};
      else
        dout = {din[7:4], din[3:0] + 4'd1};
    end else if (down && !up) begin
      if (din == '0)
        dout = BCD_MAX;
      else if (din[3:0] == 4'd0)
        dout = {din[7:4] - 4'd1, 4'd9};
      else
        dout = {din[7:4], din[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/encoder_menu_ctrl.sv
// Browse/edit/commit menu over BCD parameter registers.
// Ports: clk_in/rst_in, left/right/d pulses in; seg_data,
// seg_blank, sel_idx, mode_edit out; cfg_* commit handshake.
module encoder_menu_ctrl
  import encoder_menu_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int BLINK_HALF = 6_000_000,
  parameter int TIMEOUT    = 120_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       left_pulse,
  input  logic       right_pulse,
  input  logic       d_pulse,
  output logic [7:0] seg_data,
  output logic       seg_blank,
  output logic [1:0] sel_idx,
  output logic       mode_edit,
  output logic       cfg_valid,
  output logic [1:0] cfg_idx,
  output logic [7:0] cfg_data,
  input  logic       cfg_ready
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST = 2'(NUM_REGS - 1);

  state_t state, state_nxt;
  bcd_t   regs [4];
  bcd_t   shadow, shadow_nxt, step_q;
  bcd_t   seg_q, seg_nxt;
  bcd_t   cdata_q, cdata_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [1:0] cidx_q, cidx_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic blank_q, blank_nxt;
  logic rot_up, rot_dn, wr_en;

  // Push beats rotation; opposing rotations cancel.
  assign rot_up = right_pulse && !left_pulse && !d_pulse;
  assign rot_dn = left_pulse && !right_pulse && !d_pulse;

  bcd_step u_step (
    .din  (shadow),
    .up   (rot_up),
    .down (rot_dn),
    .dout (step_q)
  );

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_q;
    shadow_nxt = shadow;
    blink_nxt  = '0;
    idle_nxt   = '0;
    blank_nxt  = 1'b0;
    cidx_nxt   = cidx_q;
    cdata_nxt  = cdata_q;
    wr_en      = 1'b0;
    seg_nxt    = seg_q;
    unique case (state)
      BROWSE: begin
        if (d_pulse) begin
          shadow_nxt = regs[sel_q];
          state_nxt  = EDIT;
        end else if (rot_up) begin
          sel_nxt = (sel_q == LAST) ? 2'd0 : sel_q + 2'd1;
        end else if (rot_dn) begin
          sel_nxt = (sel_q == 2'd0) ? LAST : sel_q - 2'd1;
        end
      end
      EDIT: begin
        if (d_pulse) begin
          state_nxt = COMMIT;
          cidx_nxt  = sel_q;
          cdata_nxt = shadow;
        end else if (rot_up || rot_dn) begin
          // Activity restarts idle and blink (visible).
          shadow_nxt = step_q;
        end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
          state_nxt = BROWSE;
        end else begin
          idle_nxt = idle_cnt + IW'(1);
          if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_nxt = '0;
            blank_nxt = !blank_q;
          end else begin
            blink_nxt = blink_cnt + BW'(1);
            blank_nxt = blank_q;
          end
        end
      end
      COMMIT: begin
        if (cfg_ready) begin
          wr_en     = 1'b1;
          state_nxt = BROWSE;
        end
      end
      default: state_nxt = BROWSE;
    endcase
    // Display follows the state we are about to enter.
    if (state_nxt == BROWSE)
      seg_nxt = wr_en ? shadow : regs[sel_nxt];
    else
      seg_nxt = shadow_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= BROWSE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++)
        regs[i] <= '0;
      sel_q     <= '0;
      shadow    <= '0;
      seg_q     <= '0;
      blank_q   <= 1'b0;
      blink_cnt <= '0;
      idle_cnt  <= '0;
      cidx_q    <= '0;
      cdata_q   <= '0;
    end else begin
      if (wr_en)
        regs[sel_q] <= shadow;
      sel_q     <= sel_nxt;
      shadow    <= shadow_nxt;
      seg_q     <= seg_nxt;
      blank_q   <= blank_nxt;
      blink_cnt <= blink_nxt;
      idle_cnt  <= idle_nxt;
      cidx_q    <= cidx_nxt;
      cdata_q   <= cdata_nxt;
    end
  end

  assign seg_data  = seg_q;
  assign seg_blank = blank_q;
  assign sel_idx   = sel_q;
  assign mode_edit = (state != BROWSE);
  assign cfg_valid = (state == COMMIT);
  assign cfg_idx   = cidx_q;
  assign cfg_data  = cdata_q;

endmodule
